// File: rtl/uart_rx_engine.sv
// rtl/uart_rx_engine.sv - 16x-oversampled 8N1 UART receiver feeding a first-word-fall-through byte FIFO.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority voting on each deciding sample.
module uart_rx_engine #(
  parameter int FIFO_AW = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_baud_tick,
  input  logic               i_uart_rx,
  input  logic               i_pop,
  input  logic               i_clr_err,
  output logic [7:0]         o_data,
  output logic               o_empty,
  output logic               o_full,
  output logic [FIFO_AW:0]   o_count,
  output logic               o_overrun,
  output logic               o_frame_err
);

  localparam int DEPTH = 1 << FIFO_AW;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK_WAIT} state_t;

  state_t             state_q, state_d;
  logic [3:0]         tick_cnt_q, tick_cnt_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               rx_meta_q, rx_meta_d, rx_s_q, rx_s_d;
  logic [7:0]         mem_q [DEPTH], mem_d [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic               sample, push, frame_evt, do_push, do_pop, full, empty;

  assign rx_meta_d = i_uart_rx;
  assign rx_s_d    = rx_meta_q;

`ifdef UART_RX_MAJORITY_EN
  // rx_s from the two ticks preceding the current one; on a deciding tick these are ticks n-2, n-1
  logic [1:0] hist_q, hist_d;
  assign hist_d = i_baud_tick ? {hist_q[0], rx_s_q} : hist_q;
  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) hist_q <= 2'b11;
    else         hist_q <= hist_d;
  end
`else
  assign sample = rx_s_q;
`endif

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push       = 1'b0;
    frame_evt  = 1'b0;
    if (i_baud_tick) begin
      case (state_q)
        S_IDLE: begin
          if (!rx_s_q) begin
            state_d    = S_START;
            tick_cnt_d = 4'd0;
          end
        end
        S_START: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd7) begin
            // Re-zero at mid start bit so each data decision lands mid-bit
            tick_cnt_d = 4'd0;
            bit_cnt_d  = 3'd0;
            state_d    = sample ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            shift_d[bit_cnt_q] = sample;
            bit_cnt_d          = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = S_STOP;
          end
        end
        S_STOP: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            if (sample) begin
              push    = 1'b1;
              state_d = S_IDLE;
            end else begin
              frame_evt = 1'b1;
              state_d   = S_BRK_WAIT;
            end
          end
        end
        S_BRK_WAIT: begin
          if (rx_s_q) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign empty   = (count_q == '0);
  assign full    = (count_q == (FIFO_AW+1)'(DEPTH));
  assign do_pop  = i_pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + FIFO_AW'(1);
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + FIFO_AW'(1);
    count_d     = count_q + (FIFO_AW+1)'(do_push) - (FIFO_AW+1)'(do_pop);
    // A same-cycle error event outranks the clear
    overrun_d   = (push && full && !do_pop) || (overrun_q && !i_clr_err);
    frame_err_d = frame_evt || (frame_err_q && !i_clr_err);
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= S_IDLE;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rx_meta_q   <= rx_meta_d;
      rx_s_q      <= rx_s_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign o_data      = mem_q[rd_ptr_q];
  assign o_empty     = empty;
  assign o_full      = full;
  assign o_count     = count_q;
  assign o_overrun   = overrun_q;
  assign o_frame_err = frame_err_q;

endmodule

// File: tb/tb_uart_rx_engine.sv
// tb/tb_uart_rx_engine.sv - scoreboard bench for uart_rx_engine; one baud tick every 4 clocks.
module tb_uart_rx_engine;
  logic       clk = 1'b0;
  logic       i_reset, i_baud_tick, i_uart_rx, i_pop, i_clr_err;
  logic [7:0] o_data;
  logic       o_empty, o_full, o_overrun, o_frame_err;
  logic [4:0] o_count;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_q[$];
  int         model_count = 0;

  uart_rx_engine #(.FIFO_AW(4)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_baud_tick(i_baud_tick), .i_uart_rx(i_uart_rx),
    .i_pop(i_pop), .i_clr_err(i_clr_err), .o_data(o_data), .o_empty(o_empty),
    .o_full(o_full), .o_count(o_count), .o_overrun(o_overrun), .o_frame_err(o_frame_err)
  );

  always #5 clk = ~clk;

  // Line value v is seen by the DUT on the tick that ends this slot
  task automatic tick_slot(input logic v, input logic pop_here);
    i_uart_rx = v;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    i_baud_tick = 1'b1;
    i_pop       = pop_here;
    @(posedge clk); #1;
    i_baud_tick = 1'b0;
    i_pop       = 1'b0;
  endtask

  task automatic idle_slots(input int n, input logic v);
    for (int i = 0; i < n; i++) tick_slot(v, 1'b0);
  endtask

  // Slot 0 start bit, data bit k in slots 16(k+1)..+15, stop in 144..159; stop decided in slot 152
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic pop_at_push,
                            input int glitch_slot, input int nslots);
    logic       v;
    logic [7:0] e;
    for (int s = 0; s < nslots; s++) begin
      if (s < 16)       v = 1'b0;
      else if (s < 144) v = b[(s-16)>>4];
      else              v = stop_v;
      if (s == glitch_slot) v = 1'b0;
      if (s == 152 && pop_at_push) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_at_push: scoreboard empty, o_data=%h", o_data);
        end else begin
          e = exp_q.pop_front();
          if (o_data !== e) begin
            errors++;
            $display("FAIL pop_at_push: o_data=%h expected %h", o_data, e);
          end
        end
      end
      tick_slot(v, (s == 152) && pop_at_push);
    end
    if (nslots >= 153 && stop_v) begin
      if (pop_at_push) exp_q.push_back(b);
      else if (model_count < 16) begin
        exp_q.push_back(b);
        model_count++;
      end
    end
  endtask

  task automatic pop_check(input string name);
    logic [7:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, o_data=%h", name, o_data);
    end else begin
      e = exp_q.pop_front();
      if (o_data !== e) begin
        errors++;
        $display("FAIL %s: o_data=%h expected %h", name, o_data, e);
      end
    end
    i_pop = 1'b1;
    @(posedge clk); #1;
    i_pop = 1'b0;
    model_count--;
  endtask

  task automatic test_reset();
    i_reset = 1'b1; i_baud_tick = 1'b0; i_uart_rx = 1'b1; i_pop = 1'b0; i_clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({o_data, o_empty, o_full, o_count, o_overrun, o_frame_err} !== {8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: data=%h empty=%b full=%b count=%0d ovr=%b ferr=%b expected 00 1 0 0 0 0",
               o_data, o_empty, o_full, o_count, o_overrun, o_frame_err);
    end
    i_reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_frame();
    idle_slots(4, 1'b1);
    send_frame(8'h11, 1'b1, 1'b0, -1, 160);
    checks++;
    if (o_count !== 5'd1) begin
      errors++;
      $display("FAIL pre_reset_count: o_count=%0d expected 1", o_count);
    end
    send_frame(8'h5A, 1'b1, 1'b0, -1, 60);
    #2 i_reset = 1'b1;
    i_uart_rx = 1'b1;
    #1;
    checks++;
    if ({o_data, o_empty, o_full, o_count, o_overrun, o_frame_err} !== {8'h00, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: data=%h empty=%b full=%b count=%0d ovr=%b ferr=%b expected 00 1 0 0 0 0",
               o_data, o_empty, o_full, o_count, o_overrun, o_frame_err);
    end
    exp_q.delete();
    model_count = 0;
    @(posedge clk); #1;
    i_reset = 1'b0;
    idle_slots(20, 1'b1);
    send_frame(8'h33, 1'b1, 1'b0, -1, 160);
    checks++;
    if (o_count !== 5'd1 || o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_rx: count=%0d ferr=%b expected 1 0", o_count, o_frame_err);
    end
    pop_check("after_reset_data");
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, 1'b0, -1, 160);
    checks++;
    if (o_empty !== 1'b0 || o_count !== 5'd1) begin
      errors++;
      $display("FAIL single_rx: empty=%b count=%0d expected 0 1", o_empty, o_count);
    end
    pop_check("single_data");
    checks++;
    if (o_empty !== 1'b1 || o_count !== 5'd0) begin
      errors++;
      $display("FAIL single_pop: empty=%b count=%0d expected 1 0", o_empty, o_count);
    end
  endtask

  task automatic test_start_glitch();
    idle_slots(4, 1'b0);
    idle_slots(40, 1'b1);
    checks++;
    if (o_count !== 5'd0 || o_overrun !== 1'b0 || o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL start_glitch: count=%0d ovr=%b ferr=%b expected 0 0 0", o_count, o_overrun, o_frame_err);
    end
    send_frame(8'h81, 1'b1, 1'b0, -1, 160);
    pop_check("after_glitch_data");
  endtask

  task automatic test_fill_overrun();
    for (int i = 0; i <= 16; i++) send_frame(8'(i), 1'b1, 1'b0, -1, 160);
    checks++;
    if (o_full !== 1'b1 || o_count !== 5'd16 || o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL fill_overrun: full=%b count=%0d ovr=%b expected 1 16 1", o_full, o_count, o_overrun);
    end
    for (int i = 0; i < 16; i++) pop_check("fill_order");
    checks++;
    if (o_empty !== 1'b1 || o_overrun !== 1'b1) begin
      errors++;
      $display("FAIL drained: empty=%b ovr=%b expected 1 1", o_empty, o_overrun);
    end
    i_clr_err = 1'b1;
    @(posedge clk); #1;
    i_clr_err = 1'b0;
    checks++;
    if (o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL clr_overrun: ovr=%b expected 0", o_overrun);
    end
  endtask

  task automatic test_break_and_full_pushpop();
    send_frame(8'h3C, 1'b0, 1'b0, -1, 160);
    idle_slots(320, 1'b0);
    checks++;
    if (o_frame_err !== 1'b1 || o_count !== 5'd0) begin
      errors++;
      $display("FAIL frame_err: ferr=%b count=%0d expected 1 0", o_frame_err, o_count);
    end
    i_clr_err = 1'b1;
    @(posedge clk); #1;
    i_clr_err = 1'b0;
    idle_slots(320, 1'b0);
    checks++;
    if (o_frame_err !== 1'b0 || o_count !== 5'd0) begin
      errors++;
      $display("FAIL break_single_err: ferr=%b count=%0d expected 0 0", o_frame_err, o_count);
    end
    idle_slots(20, 1'b1);
    send_frame(8'h55, 1'b1, 1'b0, -1, 160);
    checks++;
    if (o_count !== 5'd1 || o_frame_err !== 1'b0) begin
      errors++;
      $display("FAIL after_break_rx: count=%0d ferr=%b expected 1 0", o_count, o_frame_err);
    end
    for (int i = 0; i < 15; i++) send_frame(8'h60 + 8'(i), 1'b1, 1'b0, -1, 160);
    checks++;
    if (o_full !== 1'b1 || o_count !== 5'd16) begin
      errors++;
      $display("FAIL refill: full=%b count=%0d expected 1 16", o_full, o_count);
    end
    send_frame(8'h7F, 1'b1, 1'b1, -1, 160);
    checks++;
    if (o_count !== 5'd16 || o_overrun !== 1'b0) begin
      errors++;
      $display("FAIL full_pushpop: count=%0d ovr=%b expected 16 0", o_count, o_overrun);
    end
    for (int i = 0; i < 16; i++) pop_check("pushpop_order");
    checks++;
    if (o_empty !== 1'b1) begin
      errors++;
      $display("FAIL pushpop_drain: empty=%b expected 1", o_empty);
    end
  endtask

  task automatic test_bit_glitch();
    logic [7:0] e;
`ifdef UART_RX_MAJORITY_EN
    e = 8'hF0;
`else
    e = 8'hD0;
`endif
    // Slot 104 is the deciding tick of data bit 5
    send_frame(8'hF0, 1'b1, 1'b0, 104, 160);
    exp_q.pop_back();
    exp_q.push_back(e);
    pop_check("bit_glitch_data");
  endtask

  initial begin
    test_reset();
    test_reset_mid_frame();
    test_single();
    test_start_glitch();
    test_fill_overrun();
    test_break_and_full_pushpop();
    test_bit_glitch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
